// File: rtl/apb_master_bridge.sv
// Command-to-APB master bridge: one outstanding transfer, decode-error handling and a
// wait-state timeout that aborts stalled ACCESS phases.
module apb_master_bridge #(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_addr,
   input  logic                  cmd_write,
   input  logic [31:0]           cmd_wdata,
   input  logic [4:0]            cmd_sel,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [31:0]           PADDR,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic                  PENABLE,
   input  logic [31:0]           PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DECERR} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_cmd_ready, w_cmd_ready_nxt;
   logic                  r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0]           r_rsp_rdata, w_rsp_rdata_nxt;
   logic                  r_rsp_err, w_rsp_err_nxt;
   logic                  r_rsp_timeout, w_rsp_timeout_nxt;
   logic [31:0]           r_paddr, w_paddr_nxt;
   logic                  r_pwrite, w_pwrite_nxt;
   logic [31:0]           r_pwdata, w_pwdata_nxt;
   logic [NUM_SLAVES-1:0] r_psel, w_psel_nxt;
   logic                  r_penable, w_penable_nxt;
   logic [CNT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;

   logic [NUM_SLAVES-1:0] w_sel_onehot;
   logic                  w_sel_ok;
   logic                  w_hs;
   logic                  w_tmo;

   // Slave decode; an out-of-range index yields an all-zero vector
   always_comb begin
      w_sel_onehot = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (cmd_sel == 5'(i)) w_sel_onehot[i] = 1'b1;
      end
   end

   assign w_sel_ok = |w_sel_onehot;
   assign w_hs     = cmd_valid & r_cmd_ready;
   // Abort when this wait cycle would bring the counter up to TIMEOUT
   assign w_tmo    = (r_state == S_ACCESS) && !PREADY &&
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_hs) w_state_nxt = w_sel_ok ? S_SETUP : S_DECERR;
         S_SETUP:  w_state_nxt = S_ACCESS;
         S_ACCESS: if (PREADY || w_tmo) w_state_nxt = S_IDLE;
         S_DECERR: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Next values for the registered outputs, derived from the transition being taken
   always_comb begin
      w_cmd_ready_nxt   = (w_state_nxt == S_IDLE);
      w_penable_nxt     = (w_state_nxt == S_ACCESS);
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_err_nxt     = r_rsp_err;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_paddr_nxt       = r_paddr;
      w_pwrite_nxt      = r_pwrite;
      w_pwdata_nxt      = r_pwdata;
      w_psel_nxt        = (w_state_nxt == S_IDLE) ? '0 : r_psel;
      w_wait_cnt_nxt    = r_wait_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_hs && w_sel_ok) begin
               w_paddr_nxt  = cmd_addr;
               w_pwrite_nxt = cmd_write;
               w_pwdata_nxt = cmd_wdata;
               w_psel_nxt   = w_sel_onehot;
            end
         end
         S_SETUP: w_wait_cnt_nxt = '0;
         S_ACCESS: begin
            if (PREADY) begin
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_err_nxt     = PSLVERR;
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_rdata_nxt   = r_pwrite ? 32'd0 : PRDATA;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
               if (w_tmo) begin
                  w_rsp_valid_nxt   = 1'b1;
                  w_rsp_err_nxt     = 1'b1;
                  w_rsp_timeout_nxt = 1'b1;
                  w_rsp_rdata_nxt   = 32'd0;
               end
            end
         end
         S_DECERR: begin
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_err_nxt     = 1'b1;
            w_rsp_timeout_nxt = 1'b0;
            w_rsp_rdata_nxt   = 32'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_paddr       <= '0;
         r_pwrite      <= 1'b0;
         r_pwdata      <= '0;
         r_psel        <= '0;
         r_penable     <= 1'b0;
         r_wait_cnt    <= '0;
      end else begin
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign PADDR       = r_paddr;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;

endmodule
